// File: rtl/operand_entry_fsm_pkg.sv
// Shared constants for the operand entry stage: state encodings and defaults.
package operand_entry_fsm_pkg;

    localparam logic [1:0] S_X    = 2'd0;
    localparam logic [1:0] S_Y    = 2'd1;
    localparam logic [1:0] S_SHOW = 2'd2;

    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    localparam int W_DEF               = 4;

    // Encoding 3 is unused; it is treated as a request to clear.
    function automatic logic is_legal_state(input logic [1:0] s);
        return (s != 2'd3);
    endfunction

endpackage

// File: rtl/operand_entry_fsm_if.sv
// Switch/button inputs and operand/status outputs of the operand entry stage.
interface operand_entry_fsm_if #(
    parameter int W = 4
);
    logic [W-1:0] SW;
    logic         SW_CIN;
    logic         KEY_ENTER_N;
    logic         KEY_CLEAR_N;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         C_IN;
    logic         VALID;
    logic [1:0]   STATE;

    modport master (
        output SW, SW_CIN, KEY_ENTER_N, KEY_CLEAR_N,
        input  X, Y, C_IN, VALID, STATE
    );

    modport slave (
        input  SW, SW_CIN, KEY_ENTER_N, KEY_CLEAR_N,
        output X, Y, C_IN, VALID, STATE
    );
endinterface

// File: rtl/operand_entry_fsm_key_debounce.sv
// Pushbutton conditioning: two-flop synchroniser, stable-count debouncer and
// a one-cycle press pulse on the debounced 1->0 transition.
module key_debounce
    import operand_entry_fsm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic KEY_N,
    output logic LEVEL,
    output logic PRESS
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             level_dly_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    // Count cycles of disagreement; any agreeing cycle restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Press is a registered edge detect on the debounced level, so holding
    // the key yields a single pulse and release yields none.
    always_comb begin
        press_d = level_dly_q & ~level_q;
    end

    // Released (1) is the reset level so a held key re-debounces after reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            level_q     <= 1'b1;
            level_dly_q <= 1'b1;
            cnt_q       <= '0;
            press_q     <= 1'b0;
        end else begin
            sync1_q     <= KEY_N;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            cnt_q       <= cnt_d;
            press_q     <= press_d;
        end
    end

    assign LEVEL = level_q;
    assign PRESS = press_q;

endmodule

// File: rtl/operand_entry_fsm.sv
// Operand entry sequencer: captures X, then Y with carry-in, from the slide
// switches on debounced ENTER presses; CLEAR zeroes everything.
//
//   state  | meaning
//   S_X    | waiting for X on the next ENTER
//   S_Y    | X held, waiting for Y and C_IN on the next ENTER
//   S_SHOW | operand set complete (VALID=1); next ENTER drops VALID
//   3      | unused; recovers to S_X with the clear actions
module operand_entry_fsm
    import operand_entry_fsm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int W               = W_DEF
) (
    input logic               CLK,
    input logic               RST_N,
    operand_entry_fsm_if.slave bus
);
    logic         enter_press, clear_press;
    logic [1:0]   level_unused;

    logic [1:0]   state_q, state_d;
    logic [W-1:0] x_q, x_d;
    logic [W-1:0] y_q, y_d;
    logic         cin_q, cin_d;
    logic         valid_q, valid_d;
    logic         do_clear;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .CLK   (CLK),
        .RST_N (RST_N),
        .KEY_N (bus.KEY_ENTER_N),
        .LEVEL (level_unused[0]),
        .PRESS (enter_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .CLK   (CLK),
        .RST_N (RST_N),
        .KEY_N (bus.KEY_CLEAR_N),
        .LEVEL (level_unused[1]),
        .PRESS (clear_press)
    );

    // CLEAR beats a coincident ENTER, which is dropped rather than queued.
    assign do_clear = clear_press | ~is_legal_state(state_q);

    // State and operand registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_X;
            x_q     <= '0;
            y_q     <= '0;
            cin_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cin_q   <= cin_d;
            valid_q <= valid_d;
        end
    end

    // Next-state: advance on ENTER, return to S_X on CLEAR or bad encoding.
    always_comb begin
        state_d = state_q;
        if (do_clear) begin
            state_d = S_X;
        end else if (enter_press) begin
            case (state_q)
                S_X:     state_d = S_Y;
                S_Y:     state_d = S_SHOW;
                S_SHOW:  state_d = S_X;
                default: state_d = S_X;
            endcase
        end
    end

    // Operand capture; registers hold unless ENTER or CLEAR acts on them.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        cin_d   = cin_q;
        valid_d = valid_q;
        if (do_clear) begin
            x_d     = '0;
            y_d     = '0;
            cin_d   = 1'b0;
            valid_d = 1'b0;
        end else if (enter_press) begin
            case (state_q)
                S_X: x_d = bus.SW;
                S_Y: begin
                    y_d     = bus.SW;
                    cin_d   = bus.SW_CIN;
                    valid_d = 1'b1;
                end
                S_SHOW:  valid_d = 1'b0;
                default: valid_d = 1'b0;
            endcase
        end
    end

    assign bus.X     = x_q;
    assign bus.Y     = y_q;
    assign bus.C_IN  = cin_q;
    assign bus.VALID = valid_q;
    assign bus.STATE = state_q;

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Directed bench for operand_entry_fsm with DEBOUNCE_CYCLES = 4.
module tb_operand_entry_fsm;
    localparam int DB = 4;
    localparam int W  = 4;

    logic clk;
    logic rst_n;
    int   tests_run    = 0;
    int   tests_failed = 0;

    operand_entry_fsm_if #(.W(W)) bus ();

    operand_entry_fsm #(.DEBOUNCE_CYCLES(DB), .W(W)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Whole output word {X, Y, C_IN, VALID, STATE}.
    function automatic logic [31:0] outs();
        return 32'({bus.X, bus.Y, bus.C_IN, bus.VALID, bus.STATE});
    endfunction

    function automatic logic [31:0] pack(input logic [3:0] x, input logic [3:0] y,
                                         input logic c, input logic v, input logic [1:0] s);
        return 32'({x, y, c, v, s});
    endfunction

    // Press the selected key(s) at a negedge, hold, release, let it settle.
    task automatic tap_key(input bit en, input bit cl, input int hold);
        @(negedge clk);
        if (en) bus.KEY_ENTER_N = 1'b0;
        if (cl) bus.KEY_CLEAR_N = 1'b0;
        repeat (hold) @(negedge clk);
        bus.KEY_ENTER_N = 1'b1;
        bus.KEY_CLEAR_N = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.SW          = '0;
        bus.SW_CIN      = 1'b0;
        bus.KEY_ENTER_N = 1'b1;
        bus.KEY_CLEAR_N = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: nothing moves.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_val("idle_outs", outs(), pack(4'h0, 4'h0, 1'b0, 1'b0, 2'd0));
        end

        // First ENTER with exact latency: pulse after 7th edge, X after 8th.
        bus.SW = 4'hA;
        @(negedge clk);
        bus.KEY_ENTER_N = 1'b0;
        repeat (DB + 3) @(posedge clk);
        @(negedge clk);
        check_val("x_before_update", outs(), pack(4'h0, 4'h0, 1'b0, 1'b0, 2'd0));
        @(negedge clk);
        check_val("x_captured", outs(), pack(4'hA, 4'h0, 1'b0, 1'b0, 2'd1));
        bus.SW = 4'h5;
        repeat (20) @(negedge clk);
        check_val("hold_one_pulse", outs(), pack(4'hA, 4'h0, 1'b0, 1'b0, 2'd1));
        bus.KEY_ENTER_N = 1'b1;
        repeat (12) @(negedge clk);
        check_val("release_no_pulse", outs(), pack(4'hA, 4'h0, 1'b0, 1'b0, 2'd1));

        // Y and carry-in.
        bus.SW     = 4'h7;
        bus.SW_CIN = 1'b1;
        tap_key(1'b1, 1'b0, 10);
        check_val("y_captured", outs(), pack(4'hA, 4'h7, 1'b1, 1'b1, 2'd2));

        // Third ENTER drops VALID, operands hold.
        bus.SW     = 4'h2;
        bus.SW_CIN = 1'b0;
        tap_key(1'b1, 1'b0, 10);
        check_val("show_exit", outs(), pack(4'hA, 4'h7, 1'b1, 1'b0, 2'd0));

        // Bounce: low 2, high 1, low 3 -> rejected.
        @(negedge clk);
        bus.KEY_ENTER_N = 1'b0;
        repeat (2) @(negedge clk);
        bus.KEY_ENTER_N = 1'b1;
        @(negedge clk);
        bus.KEY_ENTER_N = 1'b0;
        repeat (3) @(negedge clk);
        bus.KEY_ENTER_N = 1'b1;
        repeat (15) @(negedge clk);
        check_val("bounce_rejected", outs(), pack(4'hA, 4'h7, 1'b1, 1'b0, 2'd0));

        // Long hold: exactly one pulse.
        bus.SW = 4'h3;
        tap_key(1'b1, 1'b0, 30);
        check_val("long_hold_single", outs(), pack(4'h3, 4'h7, 1'b1, 1'b0, 2'd1));

        // Into S_SHOW, then coincident ENTER + CLEAR.
        bus.SW     = 4'h9;
        bus.SW_CIN = 1'b0;
        tap_key(1'b1, 1'b0, 10);
        check_val("show_again", outs(), pack(4'h3, 4'h9, 1'b0, 1'b1, 2'd2));
        bus.SW_CIN = 1'b1;
        tap_key(1'b1, 1'b1, 30);
        check_val("clear_wins", outs(), pack(4'h0, 4'h0, 1'b0, 1'b0, 2'd0));
        repeat (10) @(negedge clk);
        check_val("no_queued_enter", outs(), pack(4'h0, 4'h0, 1'b0, 1'b0, 2'd0));

        // CLEAR alone from S_Y.
        bus.SW = 4'hE;
        tap_key(1'b1, 1'b0, 10);
        check_val("x_for_clear", outs(), pack(4'hE, 4'h0, 1'b0, 1'b0, 2'd1));
        tap_key(1'b0, 1'b1, 10);
        check_val("clear_alone", outs(), pack(4'h0, 4'h0, 1'b0, 1'b0, 2'd0));

        // Async reset mid-debounce while in S_Y.
        bus.SW = 4'h6;
        tap_key(1'b1, 1'b0, 10);
        check_val("x_before_reset", outs(), pack(4'h6, 4'h0, 1'b0, 1'b0, 2'd1));
        @(negedge clk);
        bus.KEY_ENTER_N = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_val("async_reset", outs(), pack(4'h0, 4'h0, 1'b0, 1'b0, 2'd0));
        bus.SW = 4'hC;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (DB + 3) @(posedge clk);
        @(negedge clk);
        check_val("post_reset_wait", outs(), pack(4'h0, 4'h0, 1'b0, 1'b0, 2'd0));
        @(negedge clk);
        check_val("post_reset_pulse", outs(), pack(4'hC, 4'h0, 1'b0, 1'b0, 2'd1));
        repeat (20) @(negedge clk);
        check_val("post_reset_single", outs(), pack(4'hC, 4'h0, 1'b0, 1'b0, 2'd1));
        bus.KEY_ENTER_N = 1'b1;
        repeat (12) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/operand_entry_fsm.md
Name: operand_entry_fsm

Overview:
- Upstream operand-capture stage for the 4-bit adder/7-segment display stage.
- Takes slide-switch values and two active-low pushbuttons (ENTER, CLEAR), synchronises and debounces both buttons, then sequences operand entry: X first, then Y with carry-in.
- Holds the X, Y and C_IN registers that drive the adder/display stage, plus VALID and STATE status outputs.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a button level change (10 ms at 50 MHz); minimum 2; the bench uses 4.
W, 4, operand width; must match the adder width.

Ports:
CLK  in  1  system clock.
RST_N  in  1  asynchronous active-low reset.
SW  in  W  operand value from slide switches; asynchronous, sampled only on an accepted ENTER.
SW_CIN  in  1  carry-in switch; sampled with Y.
KEY_ENTER_N  in  1  raw pushbutton, active-low, asynchronous, bouncy.
KEY_CLEAR_N  in  1  raw pushbutton, active-low, asynchronous, bouncy.
X  out  W  captured operand X; feeds the adder X input.
Y  out  W  captured operand Y; feeds the adder Y input.
C_IN  out  1  captured carry-in.
VALID  out  1  high while X, Y and C_IN form a complete operand set.
STATE  out  2  current state: 0 = S_X, 1 = S_Y, 2 = S_SHOW.

Behaviour:
- Reset (RST_N low, asynchronous):
  - X = 0, Y = 0, C_IN = 0, VALID = 0, STATE = S_X.
  - Synchronisers and debounced levels = 1 (released).
  - Debounce counters = 0; no press pulse pending.
  - Release is synchronous to CLK.
- Button path, per key:
  - Two-flop synchroniser.
  - Debounce counter: counts cycles in which the synchronised level differs from the debounced level. Any cycle with equal levels clears the counter to 0, so a glitch shorter than DEBOUNCE_CYCLES is rejected.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level takes the new value on the next edge and the counter clears.
  - PRESS pulse: exactly one cycle wide, registered on the debounced 1->0 transition. Release produces no pulse.
  - Latency: the pulse is high in the cycle DEBOUNCE_CYCLES+3 rising edges after the first edge that samples the pin low.
  - Holding a key produces one pulse only. Re-arming requires a debounced release.
- FSM (acts on press pulses only):
  - S_X, ENTER: X <= SW; go to S_Y.
  - S_Y, ENTER: Y <= SW, C_IN <= SW_CIN, VALID <= 1; go to S_SHOW.
  - S_SHOW, ENTER: VALID <= 0; go to S_X. X, Y and C_IN hold their values until overwritten.
  - Any state, CLEAR: X, Y, C_IN <= 0, VALID <= 0; go to S_X.
  - ENTER and CLEAR pulses in the same cycle: CLEAR wins and ENTER is discarded, not queued.
  - Unused STATE encoding 3: go to S_X with the CLEAR actions applied.
- Output timing:
  - All outputs are registered.
  - Register updates are visible the cycle after the press pulse.
  - X and Y never change outside ENTER, CLEAR or reset.
  - SW changes have no effect between presses.
- Reset mid-debounce or mid-entry: the reset values above apply immediately; a button still held when reset releases produces a pulse after the normal debounce latency (the debounced level restarts at released).

Decomposition:
- Shared constants file: state encodings S_X, S_Y, S_SHOW as 2-bit localparams; default DEBOUNCE_CYCLES.
- Sub-module key_debounce: synchroniser, debounce counter and press-pulse generator. Parameter DEBOUNCE_CYCLES; ports CLK, RST_N, KEY_N, LEVEL, PRESS. Instantiated twice.
- Counter width = clog2(DEBOUNCE_CYCLES).
- FSM and operand registers live in operand_entry_fsm.

Test Plan:
- Reset, then hold keys released for 20 cycles: X=0, Y=0, C_IN=0, VALID=0, STATE=0, and no output changes.
- DEBOUNCE_CYCLES=4:
  - SW=4'hA, press ENTER cleanly: X=4'hA visible, STATE=1, exactly 4+3 edges after the low is first sampled plus one update cycle.
  - Then SW=4'h7, SW_CIN=1, ENTER: Y=7, C_IN=1, VALID=1, STATE=2. A third ENTER gives VALID=0, STATE=0, with X=A and Y=7 held.
- Bounce: ENTER low for 2 cycles, high 1, low 3, high: no pulse, state unchanged. Then hold low for 30 cycles: exactly one pulse.
- In S_SHOW, assert ENTER and CLEAR so their pulses coincide: X=0, Y=0, C_IN=0, VALID=0, STATE=0, and no second transition.
- Drop RST_N asynchronously mid-debounce while in S_Y: outputs reach reset values before the next clock edge. After release, a still-held key yields one pulse after the full debounce latency.
